// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: RUN/DWAIT/DRAIN/HALTED FSM producing latch enables and bubble flushes.
// Optional data-stall cycle counter on port stall_cnt is built only when STALL_CNT_EN is defined.
module pipeline_ctrl (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        dmemREN_mem,
   input  logic        dmemWEN_mem,
   input  logic        halt_mem,
   input  logic        branch_taken,
   input  logic        loaduse,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exmem_flush,
   output logic        memwb_flush,
   output logic        halted,
   output logic [1:0]  state
`ifdef STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      DWAIT  = 2'b01,
      DRAIN  = 2'b10,
      HALTED = 2'b11
   } state_t;

   state_t state_reg, state_next;
   logic   data_stall;

   // A pending MEM access without dhit freezes everything upstream of WB.
   assign data_stall = ((state_reg == RUN) || (state_reg == DWAIT)) &&
                       (dmemREN_mem || dmemWEN_mem) && !dhit;

   assign state  = state_reg;
   assign halted = (state_reg == HALTED);

   always_ff @(posedge CLK) begin
      if (RST) state_reg <= RUN;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      if (RST) begin
         state_next  = RUN;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
      end else begin
         case (state_reg)
            RUN, DWAIT: begin
               if (data_stall) begin
                  state_next  = DWAIT;
                  memwb_en    = 1'b1;
                  memwb_flush = 1'b1;
               end else begin
                  // Release from DWAIT re-evaluates the normal priority chain in the same cycle.
                  state_next = RUN;
                  pc_en      = 1'b1;
                  ifid_en    = 1'b1;
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  memwb_en   = 1'b1;
                  if (halt_mem) begin
                     state_next  = DRAIN;
                     pc_en       = 1'b0;
                     ifid_flush  = 1'b1;
                     idex_flush  = 1'b1;
                     exmem_flush = 1'b1;
                  end else if (branch_taken) begin
                     ifid_flush = 1'b1;
                     idex_flush = 1'b1;
                  end else if (loaduse) begin
                     pc_en      = 1'b0;
                     ifid_en    = 1'b0;
                     idex_flush = 1'b1;
                  end else if (!ihit) begin
                     pc_en      = 1'b0;
                     ifid_flush = 1'b1;
                  end
               end
            end
            DRAIN: begin
               state_next  = HALTED;
               ifid_en     = 1'b1;
               idex_en     = 1'b1;
               exmem_en    = 1'b1;
               memwb_en    = 1'b1;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
            end
            HALTED: begin
               state_next = HALTED;
            end
         endcase
      end
   end

`ifdef STALL_CNT_EN
   logic [31:0] stall_cnt_reg;

   // Saturating; data_stall is never true in DRAIN/HALTED, so the count freezes there.
   always_ff @(posedge CLK) begin
      if (RST)
         stall_cnt_reg <= 32'd0;
      else if (data_stall && (stall_cnt_reg != 32'hFFFF_FFFF))
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
   end

   assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have RST  in  1  synchronous active-high reset, sampled on CLK rising edge.
REQ-003 SHALL have ihit  in  1  instruction fetch complete this cycle.
REQ-004 SHALL have dhit  in  1  data access complete this cycle.
REQ-005 SHALL have dmemREN_mem, dmemWEN_mem  in  1 each  MEM-stage data read/write request.
REQ-006 SHALL have halt_mem  in  1  halt instruction in MEM stage.
REQ-007 SHALL have branch_taken  in  1  taken branch/jump resolved at EX/MEM.
REQ-008 SHALL have loaduse  in  1  ID instruction depends on EX-stage load.
REQ-009 SHALL have pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch/PC load enables.
REQ-010 SHALL have ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (zero) at next edge, overriding en.
REQ-011 SHALL have halted  out  1  pipeline stopped; state  out  2  current FSM state.
REQ-012 SHALL have stall_cnt  out  32  data-stall cycle count (only with STALL_CNT_EN).

Function
REQ-013 SHALL implement FSM states RUN=2'b00, DWAIT=2'b01, DRAIN=2'b10, HALTED=2'b11; outputs combinational from state and inputs.
REQ-014 Priority SHALL be: RST > data stall > halt > branch_taken > loaduse > ihit miss.
REQ-015 Data stall: in RUN or DWAIT, (dmemREN_mem|dmemWEN_mem)&!dhit SHALL drive pc_en, ifid_en, idex_en, exmem_en =0, memwb_en=1, memwb_flush=1; ihit ignored.
REQ-016 RUN->DWAIT SHALL occur on a data stall; DWAIT->RUN on the cycle dhit=1, all enables=1 that same cycle (zero added latency after dhit).
REQ-017 dhit=1 in the request cycle SHALL cause no stall and no state change.
REQ-018 halt_mem (no data stall) SHALL go RUN->DRAIN: pc_en=0, ifid/idex/exmem_flush=1, memwb_en=1 so halt enters WB.
REQ-019 DRAIN SHALL last exactly one cycle then enter HALTED; halted=0 in DRAIN.
REQ-020 HALTED SHALL drive all en=0, all flush=0, halted=1, and remain until RST.
REQ-021 branch_taken in RUN SHALL assert ifid_flush=1, idex_flush=1, all en=1; if concurrent with data stall, flush SHALL occur on the dhit release cycle instead.
REQ-022 loaduse (no branch/stall) SHALL drive pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; branch_taken simultaneous wins (loaduse ignored).
REQ-023 ihit=0 with no higher event SHALL drive pc_en=0, ifid_flush=1, remaining en=1.
REQ-024 Idle RUN (no events, ihit=1) SHALL drive all en=1, all flush=0.
REQ-025 Inputs in HALTED (including halt_mem, dhit) SHALL be ignored.

Reset
REQ-026 RST=1 SHALL force state=RUN, halted=0, stall_cnt=0 at next edge, from any state including DWAIT mid-access.
REQ-027 While RST=1 outputs SHALL be all en=0 and all flush=1.

Configuration
REQ-028 Macro STALL_CNT_EN defined: stall_cnt SHALL increment by 1 each cycle REQ-015 stall is active, saturating at 32'hFFFF_FFFF, frozen in HALTED.
REQ-029 STALL_CNT_EN undefined: stall_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset then ihit=1, no events for 3 cycles -> state=00, all en=1, flush=0.
REQ-031 dmemREN_mem=1, dhit=0 for 3 cycles then 1 -> state 01 for 3 cycles, memwb_flush=1, front en=0; release cycle all en=1, state 00; stall_cnt=3.
REQ-032 branch_taken=1 with loaduse=1 -> ifid_flush=idex_flush=1, pc_en=1; with dmem stall active, flush only on dhit cycle.
REQ-033 halt_mem=1 -> one DRAIN cycle (memwb_en=1, halted=0), then HALTED, halted=1 held 10 cycles despite dhit/ihit toggling.
REQ-034 RST=1 during DWAIT -> next edge state=00, stall_cnt=0, halted=0.
